fft16_seq_ctrl: RTL and testbench

- Sequencer for the 16-point streaming FFT datapath (`fft_16point`).
- Collects 16 real samples from an upstream valid/ready stream into a local buffer.
- Then, on a fixed cycle schedule, drives the FFT serial sample input and the twiddle ports of stages b, c and d (qu=3 scaled constants), and holds the FFT `clear` low for the run.
- Frames the 16 FFT outputs with a valid strobe and reports completion to a host start/done handshake.

---
 rtl/fft16_seq_ctrl_if.sv | 46 ++++
 rtl/fft16_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_fft16_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_seq_ctrl_if.sv
// Signal bundle between the 16-point FFT sequencer and its host, the upstream
// sample stream, the FFT datapath and the output frame consumer.
interface fft16_seq_ctrl_if #(
  parameter int N = 8
);
  // host start/done handshake
  logic         start;
  logic         busy;
  logic         done;
  // upstream sample stream
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  // FFT datapath control and data
  logic         fft_clear;
  logic [N-1:0] fft_a_r;
  logic [N-1:0] fft_a_im;
  logic [N-1:0] fft_b_r;
  logic [N-1:0] fft_b_im;
  logic [N-1:0] fft_c_r;
  logic [N-1:0] fft_c_im;
  logic [N-1:0] fft_d_r;
  logic [N-1:0] fft_d_im;
  logic [N-1:0] fft_y_r;
  logic [N-1:0] fft_y_im;
  // framed output stream
  logic         out_valid;
  logic [N-1:0] out_r;
  logic [N-1:0] out_im;

  // sequencer side
  modport slave (
    input  start, in_valid, in_data, fft_y_r, fft_y_im,
    output busy, done, in_ready, fft_clear,
           fft_a_r, fft_a_im, fft_b_r, fft_b_im, fft_c_r, fft_c_im, fft_d_r, fft_d_im,
           out_valid, out_r, out_im
  );

  // host / environment side
  modport master (
    output start, in_valid, in_data, fft_y_r, fft_y_im,
    input  busy, done, in_ready, fft_clear,
           fft_a_r, fft_a_im, fft_b_r, fft_b_im, fft_c_r, fft_c_im, fft_d_r, fft_d_im,
           out_valid, out_r, out_im
  );
endinterface

// File: rtl/fft16_seq_ctrl.sv
// Sequencer for the 16-point streaming FFT: buffers 16 real samples, then
// drives the serial sample input and stage b/c/d twiddles (scaled by 3) on a
// fixed schedule, frames the 16 FFT results and reports completion.
// Every output port is driven from a flop; next values are derived from the
// next state and next run counter so they line up with the counter value.
module fft16_seq_ctrl #(
  parameter int N       = 8,
  parameter int OUT_LAT = 16
) (
  input logic               clk,
  input logic               clear_n,
  fft16_seq_ctrl_if.slave   bus
);

  // Run counter must reach OUT_LAT+16 (the DONE slot) without wrapping.
  localparam int TW = $clog2(OUT_LAT + 17);

  localparam logic [TW-1:0] T_15        = TW'(15);
  localparam logic [TW-1:0] T_16        = TW'(16);
  localparam logic [TW-1:0] T_19        = TW'(19);
  localparam logic [TW-1:0] T_23        = TW'(23);
  localparam logic [TW-1:0] T_24        = TW'(24);
  localparam logic [TW-1:0] T_27        = TW'(27);
  localparam logic [TW-1:0] T_29        = TW'(29);
  localparam logic [TW-1:0] T_FIRST_OUT = TW'(OUT_LAT);
  localparam logic [TW-1:0] T_LAST      = TW'(OUT_LAT + 15);

  // 4-bit two's complement twiddle magnitudes
  localparam logic [3:0] P3 = 4'd3;
  localparam logic [3:0] P2 = 4'd2;
  localparam logic [3:0] P1 = 4'd1;
  localparam logic [3:0] Z0 = 4'd0;
  localparam logic [3:0] M1 = 4'hF;
  localparam logic [3:0] M2 = 4'hE;
  localparam logic [3:0] M3 = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sign-extend a 4-bit twiddle component to the datapath width.
  function automatic logic [N-1:0] sx4(input logic [3:0] v);
    sx4 = {{(N-4){v[3]}}, v};
  endfunction

  // W16^k, k=0..7, packed {re, im}
  function automatic logic [2*N-1:0] w16_lut(input logic [2:0] k);
    case (k)
      3'd0:    w16_lut = {sx4(P3), sx4(Z0)};
      3'd1:    w16_lut = {sx4(P3), sx4(M1)};
      3'd2:    w16_lut = {sx4(P2), sx4(M2)};
      3'd3:    w16_lut = {sx4(P1), sx4(M3)};
      3'd4:    w16_lut = {sx4(Z0), sx4(M3)};
      3'd5:    w16_lut = {sx4(M1), sx4(M3)};
      3'd6:    w16_lut = {sx4(M2), sx4(M2)};
      3'd7:    w16_lut = {sx4(M3), sx4(M1)};
      default: w16_lut = {(2*N){1'b0}};
    endcase
  endfunction

  // W8^k, k=0..3, packed {re, im}
  function automatic logic [2*N-1:0] w8_lut(input logic [1:0] k);
    case (k)
      2'd0:    w8_lut = {sx4(P3), sx4(Z0)};
      2'd1:    w8_lut = {sx4(P2), sx4(M2)};
      2'd2:    w8_lut = {sx4(Z0), sx4(M3)};
      2'd3:    w8_lut = {sx4(M2), sx4(M2)};
      default: w8_lut = {(2*N){1'b0}};
    endcase
  endfunction

  // W4^k, k=0..1, packed {re, im}
  function automatic logic [2*N-1:0] w4_lut(input logic k);
    case (k)
      1'b0:    w4_lut = {sx4(P3), sx4(Z0)};
      1'b1:    w4_lut = {sx4(Z0), sx4(M3)};
      default: w4_lut = {(2*N){1'b0}};
    endcase
  endfunction

  state_t         r_state;
  state_t         w_next_state;
  logic [3:0]     r_wr_cnt;
  logic [3:0]     w_wr_cnt_next;
  logic [TW-1:0]  r_t;
  logic [TW-1:0]  w_t_next;
  logic [N-1:0]   r_buf [16];
  logic           w_accept;
  logic           w_cap;

  logic [N-1:0]   w_a_r_next;
  logic [2*N-1:0] w_b_next;
  logic [2*N-1:0] w_c_next;
  logic [2*N-1:0] w_d_next;

  logic           r_busy;
  logic           r_done;
  logic           r_in_ready;
  logic           r_fft_clear;
  logic           r_out_valid;
  logic [N-1:0]   r_fft_a_r;
  logic [N-1:0]   r_fft_b_r;
  logic [N-1:0]   r_fft_b_im;
  logic [N-1:0]   r_fft_c_r;
  logic [N-1:0]   r_fft_c_im;
  logic [N-1:0]   r_fft_d_r;
  logic [N-1:0]   r_fft_d_im;
  logic [N-1:0]   r_out_r;
  logic [N-1:0]   r_out_im;

  // in_ready is high exactly in FILL, so this is the stream handshake.
  assign w_accept = (r_state == S_FILL) && bus.in_valid && r_in_ready;

  // FFT results are captured while t is in the output window of the run.
  assign w_cap = (r_state == S_RUN) && (r_t >= T_FIRST_OUT) && (r_t <= T_LAST);

  // State, write counter and run counter registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= S_IDLE;
      r_wr_cnt <= 4'd0;
      r_t      <= {TW{1'b0}};
    end else begin
      r_state  <= w_next_state;
      r_wr_cnt <= w_wr_cnt_next;
      r_t      <= w_t_next;
    end
  end

  // Next-state and counter logic: IDLE -> FILL -> RUN -> DONE -> IDLE.
  always_comb begin
    w_next_state  = r_state;
    w_wr_cnt_next = r_wr_cnt;
    w_t_next      = r_t;
    case (r_state)
      S_IDLE: begin
        w_wr_cnt_next = 4'd0;
        w_t_next      = {TW{1'b0}};
        if (bus.start) begin
          w_next_state = S_FILL;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_accept) begin
          w_wr_cnt_next = r_wr_cnt + 4'd1;
          if (r_wr_cnt == 4'd15) begin
            w_next_state = S_RUN;
            w_t_next     = {TW{1'b0}};
          end else begin
            w_next_state = S_FILL;
          end
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_RUN: begin
        w_t_next = r_t + {{(TW-1){1'b0}}, 1'b1};
        if (r_t == T_LAST) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        w_next_state  = S_IDLE;
        w_wr_cnt_next = 4'd0;
        w_t_next      = {TW{1'b0}};
      end
      default: begin
        w_next_state  = S_IDLE;
        w_wr_cnt_next = 4'd0;
        w_t_next      = {TW{1'b0}};
      end
    endcase
  end

  // Sample feed and twiddle schedule for the counter value of the next cycle.
  always_comb begin
    w_a_r_next = {N{1'b0}};
    w_b_next   = {(2*N){1'b0}};
    w_c_next   = {(2*N){1'b0}};
    w_d_next   = {(2*N){1'b0}};
    if (w_next_state == S_RUN) begin
      if (w_t_next <= T_15) begin
        w_a_r_next = r_buf[w_t_next[3:0]];
      end else begin
        w_a_r_next = {N{1'b0}};
      end
      // stage b: W16^(t-16) over t=16..23
      if ((w_t_next >= T_16) && (w_t_next <= T_23)) begin
        w_b_next = w16_lut(w_t_next[2:0]);
      end else begin
        w_b_next = {(2*N){1'b0}};
      end
      // stage c: W8^((t-16) mod 4) over t=16..19 and 24..27
      if (((w_t_next >= T_16) && (w_t_next <= T_19)) ||
          ((w_t_next >= T_24) && (w_t_next <= T_27))) begin
        w_c_next = w8_lut(w_t_next[1:0]);
      end else begin
        w_c_next = {(2*N){1'b0}};
      end
      // stage d: W4^((t-16) mod 2) on the first two slots of each group of four
      if ((w_t_next >= T_16) && (w_t_next <= T_29) && (w_t_next[1] == 1'b0)) begin
        w_d_next = w4_lut(w_t_next[0]);
      end else begin
        w_d_next = {(2*N){1'b0}};
      end
    end else begin
      w_a_r_next = {N{1'b0}};
      w_b_next   = {(2*N){1'b0}};
      w_c_next   = {(2*N){1'b0}};
      w_d_next   = {(2*N){1'b0}};
    end
  end

  // Sample buffer: cleared on reset so it never presents unknown data.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= {N{1'b0}};
      end
    end else if (w_accept) begin
      r_buf[r_wr_cnt] <= bus.in_data;
    end
  end

  // Registered status, FFT drive and output-frame signals.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_fft_clear <= 1'b1;
      r_out_valid <= 1'b0;
      r_fft_a_r   <= {N{1'b0}};
      r_fft_b_r   <= {N{1'b0}};
      r_fft_b_im  <= {N{1'b0}};
      r_fft_c_r   <= {N{1'b0}};
      r_fft_c_im  <= {N{1'b0}};
      r_fft_d_r   <= {N{1'b0}};
      r_fft_d_im  <= {N{1'b0}};
      r_out_r     <= {N{1'b0}};
      r_out_im    <= {N{1'b0}};
    end else begin
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= (w_next_state == S_DONE);
      r_in_ready  <= (w_next_state == S_FILL);
      r_fft_clear <= (w_next_state != S_RUN);
      r_out_valid <= w_cap;
      r_fft_a_r   <= w_a_r_next;
      {r_fft_b_r, r_fft_b_im} <= w_b_next;
      {r_fft_c_r, r_fft_c_im} <= w_c_next;
      {r_fft_d_r, r_fft_d_im} <= w_d_next;
      if (w_cap) begin
        r_out_r  <= bus.fft_y_r;
        r_out_im <= bus.fft_y_im;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.in_ready  = r_in_ready;
  assign bus.fft_clear = r_fft_clear;
  assign bus.fft_a_r   = r_fft_a_r;
  assign bus.fft_a_im  = {N{1'b0}};
  assign bus.fft_b_r   = r_fft_b_r;
  assign bus.fft_b_im  = r_fft_b_im;
  assign bus.fft_c_r   = r_fft_c_r;
  assign bus.fft_c_im  = r_fft_c_im;
  assign bus.fft_d_r   = r_fft_d_r;
  assign bus.fft_d_im  = r_fft_d_im;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_im    = r_out_im;

endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// Directed bench for fft16_seq_ctrl with OUT_LAT=20 and a stub FFT that
// drives fft_y_r = t and fft_y_im = t+100 during the run.
module tb_fft16_seq_ctrl;
  localparam int N       = 8;
  localparam int OUT_LAT = 20;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  int samp_a [16] = '{1, 2, 5, 6, 8, 1, 2, 3, 2, 4, 3, 2, 1, 3, 6, 9};
  int samp_b [16] = '{-5, 7, 100, -128, 127, 0, 11, -1, 33, 44, -20, 9, 8, 7, 6, 5};
  int samp_c [16] = '{16, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};

  int w16_re [8] = '{3, 3, 2, 1, 0, -1, -2, -3};
  int w16_im [8] = '{0, -1, -2, -3, -3, -3, -2, -1};
  int w8_re  [4] = '{3, 2, 0, -2};
  int w8_im  [4] = '{0, -2, -3, -2};
  int w4_re  [2] = '{3, 0};
  int w4_im  [2] = '{0, -3};

  fft16_seq_ctrl_if #(.N(N)) bus ();

  fft16_seq_ctrl #(.N(N), .OUT_LAT(OUT_LAT)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
    bus.fft_y_r = 8'd0; bus.fft_y_im = 8'd0;
    clear_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.fft_clear} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00001",
               {bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.fft_clear});
    end
    n_checks++;
    if ({bus.fft_a_r, bus.fft_a_im, bus.fft_b_r, bus.fft_b_im, bus.fft_c_r, bus.fft_c_im,
         bus.fft_d_r, bus.fft_d_im, bus.out_r, bus.out_im} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_data: got a_r=%h b_r=%h c_r=%h d_r=%h out_r=%h want all 0",
               bus.fft_a_r, bus.fft_b_r, bus.fft_c_r, bus.fft_d_r, bus.out_r);
    end
    tick();
    clear_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.in_ready, bus.fft_clear} !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_idle: got %b want 001", {bus.busy, bus.in_ready, bus.fft_clear});
      end
      tick();
    end
  endtask

  task automatic test_run();
    int ea, ebr, ebi, ecr, eci, edr, edi;
    bus.start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL run_start_idle: busy got %b want 0", bus.busy);
    end
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(samp_a[i]);
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.in_ready, bus.fft_clear} !== 3'b111) begin
        n_fail++;
        $display("FAIL run_fill[%0d]: busy/in_ready/clear got %b want 111", i,
                 {bus.busy, bus.in_ready, bus.fft_clear});
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t <= OUT_LAT + 15; t++) begin
      bus.fft_y_r  = 8'(t);
      bus.fft_y_im = 8'(t + 100);
      @(negedge clk);
      ea = (t < 16) ? samp_a[t] : 0;
      n_checks++;
      if ($signed(bus.fft_a_r) !== ea || bus.fft_a_im !== 8'd0) begin
        n_fail++;
        $display("FAIL run_a t=%0d: got %0d/%0d want %0d/0", t,
                 $signed(bus.fft_a_r), $signed(bus.fft_a_im), ea);
      end
      n_checks++;
      if ({bus.busy, bus.in_ready, bus.fft_clear, bus.done} !== 4'b1000) begin
        n_fail++;
        $display("FAIL run_ctrl t=%0d: busy/in_ready/clear/done got %b want 1000", t,
                 {bus.busy, bus.in_ready, bus.fft_clear, bus.done});
      end
      ebr = 0; ebi = 0; ecr = 0; eci = 0; edr = 0; edi = 0;
      if (t >= 16 && t <= 23) begin
        ebr = w16_re[t-16]; ebi = w16_im[t-16];
      end
      if ((t >= 16 && t <= 19) || (t >= 24 && t <= 27)) begin
        ecr = w8_re[(t-16)%4]; eci = w8_im[(t-16)%4];
      end
      if (t == 16 || t == 17 || t == 20 || t == 21 || t == 24 || t == 25 || t == 28 || t == 29) begin
        edr = w4_re[(t-16)%2]; edi = w4_im[(t-16)%2];
      end
      n_checks++;
      if ($signed(bus.fft_b_r) !== ebr || $signed(bus.fft_b_im) !== ebi ||
          $signed(bus.fft_c_r) !== ecr || $signed(bus.fft_c_im) !== eci ||
          $signed(bus.fft_d_r) !== edr || $signed(bus.fft_d_im) !== edi) begin
        n_fail++;
        $display("FAIL run_twiddle t=%0d: got b=(%0d,%0d) c=(%0d,%0d) d=(%0d,%0d) want b=(%0d,%0d) c=(%0d,%0d) d=(%0d,%0d)",
                 t, $signed(bus.fft_b_r), $signed(bus.fft_b_im), $signed(bus.fft_c_r),
                 $signed(bus.fft_c_im), $signed(bus.fft_d_r), $signed(bus.fft_d_im),
                 ebr, ebi, ecr, eci, edr, edi);
      end
      n_checks++;
      if (bus.out_valid !== (t >= OUT_LAT + 1)) begin
        n_fail++;
        $display("FAIL run_out_valid t=%0d: got %b want %b", t, bus.out_valid, (t >= OUT_LAT + 1));
      end
      if (t >= OUT_LAT + 1) begin
        n_checks++;
        if (bus.out_r !== 8'(t - 1) || bus.out_im !== 8'(t + 99)) begin
          n_fail++;
          $display("FAIL run_out_data t=%0d: got %0d/%0d want %0d/%0d", t,
                   bus.out_r, bus.out_im, t - 1, t + 99);
        end
      end
      tick();
    end
    // DONE slot, t = OUT_LAT+16
    bus.fft_y_r = 8'hAA; bus.fft_y_im = 8'h55;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.in_ready, bus.fft_clear, bus.out_valid} !== 5'b11011) begin
      n_fail++;
      $display("FAIL run_done: busy/done/in_ready/clear/out_valid got %b want 11011",
               {bus.busy, bus.done, bus.in_ready, bus.fft_clear, bus.out_valid});
    end
    n_checks++;
    if (bus.out_r !== 8'(OUT_LAT + 15) || bus.out_im !== 8'(OUT_LAT + 115)) begin
      n_fail++;
      $display("FAIL run_done_data: got %0d/%0d want %0d/%0d", bus.out_r, bus.out_im,
               OUT_LAT + 15, OUT_LAT + 115);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.out_valid, bus.fft_clear} !== 4'b0001 ||
          bus.out_r !== 8'(OUT_LAT + 15)) begin
        n_fail++;
        $display("FAIL run_after_done: ctrl got %b want 0001, out_r got %0d want %0d",
                 {bus.busy, bus.done, bus.out_valid, bus.fft_clear}, bus.out_r, OUT_LAT + 15);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(samp_a[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    @(negedge clk);
    n_checks++;
    if ($signed(bus.fft_a_r) !== samp_a[5] || bus.fft_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre t=5: a_r got %0d want %0d, clear got %b want 0",
               $signed(bus.fft_a_r), samp_a[5], bus.fft_clear);
    end
    #2;
    clear_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.fft_clear} !== 5'b00001 ||
        bus.fft_a_r !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_async: ctrl got %b want 00001, a_r got %0d want 0",
               {bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.fft_clear}, bus.fft_a_r);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_done: done got %b want 0", bus.done);
      end
    end
    clear_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.in_ready, bus.done, bus.fft_clear} !== 4'b0001) begin
        n_fail++;
        $display("FAIL abort_idle: busy/in_ready/done/clear got %b want 0001",
                 {bus.busy, bus.in_ready, bus.done, bus.fft_clear});
      end
      tick();
    end
  endtask

  task automatic test_toggle_valid();
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL toggle_idle_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      bus.in_valid = (k % 2 == 1);
      bus.in_data  = (k % 2 == 1) ? 8'(samp_c[k/2]) : 8'h77;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL toggle_fill[%0d]: in_ready got %b want 1", k, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.fft_clear} !== 3'b010) begin
      n_fail++;
      $display("FAIL toggle_run_start: in_ready/busy/clear got %b want 010",
               {bus.in_ready, bus.busy, bus.fft_clear});
    end
    for (int t = 0; t <= OUT_LAT + 16; t++) begin
      if (t > 0) @(negedge clk);
      if (t < 16) begin
        n_checks++;
        if ($signed(bus.fft_a_r) !== samp_c[t]) begin
          n_fail++;
          $display("FAIL toggle_order t=%0d: got %0d want %0d", t, $signed(bus.fft_a_r), samp_c[t]);
        end
      end
      if (t == OUT_LAT + 16) begin
        n_checks++;
        if (bus.done !== 1'b1) begin
          n_fail++; $display("FAIL toggle_done: got %b want 1", bus.done);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(samp_a[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t <= OUT_LAT + 16; t++) begin
      @(negedge clk);
      if (t == OUT_LAT + 16) begin
        n_checks++;
        if (bus.done !== 1'b1) begin
          n_fail++; $display("FAIL b2b_done1: got %b want 1", bus.done);
        end
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.in_ready, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_gap: busy/in_ready/done got %b want 000", {bus.busy, bus.in_ready, bus.done});
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(samp_b[i]);
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.in_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b_fill2[%0d]: busy/in_ready got %b want 11", i, {bus.busy, bus.in_ready});
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t <= OUT_LAT + 16; t++) begin
      @(negedge clk);
      if (t < 16) begin
        n_checks++;
        if ($signed(bus.fft_a_r) !== samp_b[t]) begin
          n_fail++;
          $display("FAIL b2b_data2 t=%0d: got %0d want %0d", t, $signed(bus.fft_a_r), samp_b[t]);
        end
      end
      if (t == OUT_LAT + 16) begin
        n_checks++;
        if (bus.done !== 1'b1) begin
          n_fail++; $display("FAIL b2b_done2: got %b want 1", bus.done);
        end
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.in_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL b2b_stop: busy/in_ready got %b want 00", {bus.busy, bus.in_ready});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_reset_mid_run();
    test_toggle_valid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
